// File: rtl/id_operand_stage.sv
// -----------------------------------------------------------------------------
// id_operand_stage
//   Decode/operand stage between fetch and execute. It holds the FS->DS
//   pipeline register and the valid/allowin handshake. The stage exports the
//   held instruction to an external combinational decoder and gets the decode
//   results back. It resolves the rs/rt operands from the register file and
//   from NUM_FWD prioritised forwarding sources. A per-register scoreboard
//   tracks outstanding long-latency writes.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   es_allowin / ds_allowin       downstream / upstream accept handshake
//   fs_to_ds_valid, fs_to_ds_bus  incoming {pc, inst}
//   ds_flush                      kill the instruction held in DS
//   ds_inst, ds_pc                held instruction and pc
//   dec_*                         decode results for ds_inst
//   rs_addr/rt_addr, rs_data/rt_data   register-file read port
//   fwd_we/waddr/wdata/rdy        forwarding sources, index 0 is youngest
//   lp_done_valid/waddr           long-latency write-back notification
//   ds_to_es_valid                issue valid
//   ds_rs_val, ds_rt_val          resolved operands
//   stall_cnt                     saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module id_operand_stage #(
  parameter int NUM_FWD  = 3,
  parameter int DW       = 32,
  parameter int BUS_WD   = 64,
  parameter int MAX_LONG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_allowin,
  output logic                 ds_allowin,
  input  logic                 fs_to_ds_valid,
  input  logic [BUS_WD-1:0]    fs_to_ds_bus,
  input  logic                 ds_flush,
  output logic [31:0]          ds_inst,
  output logic [31:0]          ds_pc,
  input  logic                 dec_rs_used,
  input  logic                 dec_rt_used,
  input  logic                 dec_rf_we,
  input  logic [4:0]           dec_rf_waddr,
  input  logic                 dec_long_op,
  output logic [4:0]           rs_addr,
  output logic [4:0]           rt_addr,
  input  logic [DW-1:0]        rs_data,
  input  logic [DW-1:0]        rt_data,
  input  logic [NUM_FWD-1:0]   fwd_we,
  input  logic [5*NUM_FWD-1:0] fwd_waddr,
  input  logic [DW*NUM_FWD-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]   fwd_rdy,
  input  logic                 lp_done_valid,
  input  logic [4:0]           lp_done_waddr,
  output logic                 ds_to_es_valid,
  output logic [DW-1:0]        ds_rs_val,
  output logic [DW-1:0]        ds_rt_val,
  output logic [31:0]          stall_cnt
);

  localparam logic [3:0] LONG_MAX_C = 4'(MAX_LONG);

  logic              ds_valid_r;
  logic [BUS_WD-1:0] ds_bus_r;
  logic [31:0]       pend_r;
  logic [3:0]        long_cnt_r;
  logic [31:0]       stall_cnt_r;

  logic              rs_hit_s, rt_hit_s;
  logic              rs_rdy_s, rt_rdy_s;
  logic [DW-1:0]     rs_fwd_s, rt_fwd_s;
  logic              hazard_rs_s, hazard_rt_s, long_full_s, hazard_s;
  logic              ready_go_s, allowin_s, issue_s;
  logic              sb_set_s, sb_clr_s;
  logic [31:0]       pend_nxt_s;
  logic [3:0]        long_cnt_nxt_s;
  logic              stall_inc_s;

  assign ds_inst   = ds_bus_r[31:0];
  assign ds_pc     = ds_bus_r[63:32];
  assign rs_addr   = ds_inst[25:21];
  assign rt_addr   = ds_inst[20:16];
  assign stall_cnt = stall_cnt_r;

  // Forwarding source selection: the first matching source in index order wins,
  // whether or not it is ready, so an older ready value can never shadow it.
  always_comb begin
    rs_hit_s = 1'b0;
    rs_rdy_s = 1'b0;
    rs_fwd_s = '0;
    rt_hit_s = 1'b0;
    rt_rdy_s = 1'b0;
    rt_fwd_s = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      logic take_rs;
      logic take_rt;
      take_rs  = fwd_we[i] & (fwd_waddr[5*i +: 5] == rs_addr) & (rs_addr != 5'd0) & ~rs_hit_s;
      take_rt  = fwd_we[i] & (fwd_waddr[5*i +: 5] == rt_addr) & (rt_addr != 5'd0) & ~rt_hit_s;
      rs_rdy_s = take_rs ? fwd_rdy[i] : rs_rdy_s;
      rs_fwd_s = take_rs ? fwd_wdata[DW*i +: DW] : rs_fwd_s;
      rt_rdy_s = take_rt ? fwd_rdy[i] : rt_rdy_s;
      rt_fwd_s = take_rt ? fwd_wdata[DW*i +: DW] : rt_fwd_s;
      rs_hit_s = rs_hit_s | take_rs;
      rt_hit_s = rt_hit_s | take_rt;
    end
  end

  // Operand values: r0 reads as zero, then forwarded data, then RF data.
  always_comb begin
    ds_rs_val = (rs_addr == 5'd0) ? '0 : (rs_hit_s ? rs_fwd_s : rs_data);
    ds_rt_val = (rt_addr == 5'd0) ? '0 : (rt_hit_s ? rt_fwd_s : rt_data);
  end

  // Hazard detection and handshake.
  always_comb begin
    hazard_rs_s    = dec_rs_used & (rs_addr != 5'd0) & (pend_r[rs_addr] | (rs_hit_s & ~rs_rdy_s));
    hazard_rt_s    = dec_rt_used & (rt_addr != 5'd0) & (pend_r[rt_addr] | (rt_hit_s & ~rt_rdy_s));
    long_full_s    = dec_long_op & dec_rf_we & (long_cnt_r == LONG_MAX_C);
    hazard_s       = ds_valid_r & (hazard_rs_s | hazard_rt_s | long_full_s);
    ready_go_s     = ~hazard_s;
    allowin_s      = ~ds_valid_r | (ready_go_s & es_allowin);
    ds_to_es_valid = ds_valid_r & ready_go_s & ~ds_flush;
    issue_s        = ds_to_es_valid & es_allowin;
    ds_allowin     = allowin_s;
  end

  // Scoreboard next state: a set and a clear in the same cycle cancel in the
  // count, and the set wins on the pend bit when both target one register.
  always_comb begin
    sb_set_s   = issue_s & dec_long_op & dec_rf_we & (dec_rf_waddr != 5'd0);
    sb_clr_s   = lp_done_valid & pend_r[lp_done_waddr];
    pend_nxt_s = (pend_r & ~({31'd0, sb_clr_s} << lp_done_waddr))
               | ({31'd0, sb_set_s} << dec_rf_waddr);
    case ({sb_set_s, sb_clr_s})
      2'b10:   long_cnt_nxt_s = (long_cnt_r != LONG_MAX_C) ? long_cnt_r + 4'd1 : long_cnt_r;
      2'b01:   long_cnt_nxt_s = (long_cnt_r != 4'd0) ? long_cnt_r - 4'd1 : long_cnt_r;
      default: long_cnt_nxt_s = long_cnt_r;
    endcase
    stall_inc_s = hazard_s & es_allowin & (stall_cnt_r != 32'hFFFF_FFFF);
  end

  // FS->DS pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_r <= 1'b0;
      ds_bus_r   <= '0;
    end else if (allowin_s) begin
      ds_valid_r <= fs_to_ds_valid & ~ds_flush;
      ds_bus_r   <= fs_to_ds_valid ? fs_to_ds_bus : ds_bus_r;
    end else if (ds_flush) begin
      ds_valid_r <= 1'b0;
    end else begin
      ds_valid_r <= ds_valid_r;
    end
  end

  // Scoreboard pend bits and outstanding long-op count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r     <= 32'd0;
      long_cnt_r <= 4'd0;
    end else begin
      pend_r     <= pend_nxt_s;
      long_cnt_r <= long_cnt_nxt_s;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_inc_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_operand_stage
//   Self-checking bench for id_operand_stage (built with MAX_LONG = 2).
//   A table of forwarding vectors, a randomized run against a behavioural
//   model, and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_id_operand_stage;

  localparam int MAXL = 2;

  logic        clk;
  logic        reset;
  logic        es_allowin;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        ds_flush;
  logic [31:0] ds_inst;
  logic [31:0] ds_pc;
  logic        dec_rs_used;
  logic        dec_rt_used;
  logic        dec_rf_we;
  logic [4:0]  dec_rf_waddr;
  logic        dec_long_op;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [2:0]  fwd_rdy;
  logic        lp_done_valid;
  logic [4:0]  lp_done_waddr;
  logic        ds_to_es_valid;
  logic [31:0] ds_rs_val;
  logic [31:0] ds_rt_val;
  logic [31:0] stall_cnt;

  id_operand_stage #(.NUM_FWD(3), .DW(32), .BUS_WD(64), .MAX_LONG(MAXL)) dut (
    .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .ds_flush(ds_flush),
    .ds_inst(ds_inst), .ds_pc(ds_pc), .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_rf_we(dec_rf_we), .dec_rf_waddr(dec_rf_waddr), .dec_long_op(dec_long_op),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy),
    .lp_done_valid(lp_done_valid), .lp_done_waddr(lp_done_waddr),
    .ds_to_es_valid(ds_to_es_valid), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_valid;
  bit [63:0]   m_bus;
  bit          m_pend [32];
  int          m_cnt;
  bit [31:0]   m_stall;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(logic [4:0] rs, logic [4:0] rt);
    return {6'h23, rs, rt, 16'h0040};
  endfunction

  function automatic logic [4:0] rr();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd3;
      2:       return 5'd8;
      default: return 5'd9;
    endcase
  endfunction

  // Highest-priority forwarding source writing register x, or -1.
  function automatic int pick_src(int x);
    for (int i = 0; i < 3; i++)
      if (fwd_we[i] && int'(fwd_waddr[5*i +: 5]) == x && x != 0) return i;
    return -1;
  endfunction

  function automatic logic [31:0] operand(int x, logic [31:0] rf);
    int s;
    s = pick_src(x);
    if (x == 0) return 32'd0;
    if (s >= 0) return fwd_wdata[32*s +: 32];
    return rf;
  endfunction

  function automatic bit blocked(int x, bit used);
    int s;
    s = pick_src(x);
    if (!used || x == 0) return 1'b0;
    if (m_pend[x]) return 1'b1;
    return (s >= 0) && !fwd_rdy[s];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = 64'd0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt   = 0;
    m_stall = 32'd0;
  endtask

  task automatic idle();
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = 64'd0;
    ds_flush       = 1'b0;
    dec_rs_used    = 1'b0;
    dec_rt_used    = 1'b0;
    dec_rf_we      = 1'b0;
    dec_rf_waddr   = 5'd0;
    dec_long_op    = 1'b0;
    rs_data        = 32'hAAAA_0001;
    rt_data        = 32'hBBBB_0002;
    fwd_we         = 3'b000;
    fwd_waddr      = 15'd0;
    fwd_wdata      = 96'd0;
    fwd_rdy        = 3'b111;
    lp_done_valid  = 1'b0;
    lp_done_waddr  = 5'd0;
  endtask

  task automatic load(logic [31:0] pc, logic [31:0] inst);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {pc, inst};
  endtask

  task automatic long_to(logic [4:0] r);
    dec_long_op  = 1'b1;
    dec_rf_we    = 1'b1;
    dec_rf_waddr = r;
  endtask

  // One clock: compare DUT against the model at negedge, advance at posedge.
  task automatic cycle();
    int rs, rt, nc;
    bit haz, allow, vout, iss, setb, clrb, nv;
    bit [63:0] nb;
    bit np [32];
    bit [31:0] ns;
    @(negedge clk);
    rs    = int'(m_bus[25:21]);
    rt    = int'(m_bus[20:16]);
    haz   = m_valid && (blocked(rs, dec_rs_used) || blocked(rt, dec_rt_used) ||
                        (dec_long_op && dec_rf_we && m_cnt == MAXL));
    allow = !m_valid || (!haz && es_allowin);
    vout  = m_valid && !haz && !ds_flush;
    iss   = vout && es_allowin;
    chkb("ds_allowin", ds_allowin, allow);
    chkb("ds_to_es_valid", ds_to_es_valid, vout);
    chk("ds_inst", ds_inst, m_bus[31:0]);
    chk("ds_pc", ds_pc, m_bus[63:32]);
    chk("rs_addr", 32'(rs_addr), 32'(rs));
    chk("rt_addr", 32'(rt_addr), 32'(rt));
    chk("ds_rs_val", ds_rs_val, operand(rs, rs_data));
    chk("ds_rt_val", ds_rt_val, operand(rt, rt_data));
    chk("stall_cnt", stall_cnt, m_stall);
    nv = m_valid;
    nb = m_bus;
    if (allow) begin
      nv = fs_to_ds_valid && !ds_flush;
      if (fs_to_ds_valid) nb = fs_to_ds_bus;
    end else if (ds_flush) begin
      nv = 1'b0;
    end
    setb = iss && dec_long_op && dec_rf_we && dec_rf_waddr != 5'd0;
    clrb = lp_done_valid && m_pend[lp_done_waddr];
    np   = m_pend;
    if (clrb) np[lp_done_waddr] = 1'b0;
    if (setb) np[dec_rf_waddr] = 1'b1;
    nc = m_cnt + ((setb && !clrb) ? 1 : 0) - ((clrb && !setb) ? 1 : 0);
    ns = (haz && es_allowin && m_stall != 32'hFFFF_FFFF) ? m_stall + 32'd1 : m_stall;
    @(posedge clk);
    m_valid = nv;
    m_bus   = nb;
    m_pend  = np;
    m_cnt   = nc;
    m_stall = ns;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  we;
    logic [14:0] waddr;   // {src2, src1, src0}
    logic [2:0]  rdy;
    logic [31:0] d0;
    logic        rs_used;
    logic        rt_used;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic        exp_go;
  } vec_t;

  vec_t vt [9];

  localparam logic [31:0] RA = 32'hAAAA_0001;
  localparam logic [31:0] RB = 32'hBBBB_0002;

  initial begin
    vt[0] = '{5'd8, 5'd9, 3'b101, {5'd8, 5'd0, 5'd8}, 3'b111, 32'h11,   1'b1, 1'b1, 32'h11, RB,     1'b1};
    vt[1] = '{5'd8, 5'd9, 3'b101, {5'd8, 5'd0, 5'd8}, 3'b110, 32'h11,   1'b1, 1'b1, 32'h11, RB,     1'b0};
    vt[2] = '{5'd0, 5'd9, 3'b001, {5'd0, 5'd0, 5'd0}, 3'b000, 32'hFFFF, 1'b1, 1'b1, 32'h0,  RB,     1'b1};
    vt[3] = '{5'd8, 5'd9, 3'b110, {5'd9, 5'd9, 5'd0}, 3'b010, 32'h11,   1'b1, 1'b1, RA,     32'h22, 1'b1};
    vt[4] = '{5'd8, 5'd9, 3'b110, {5'd9, 5'd9, 5'd0}, 3'b100, 32'h11,   1'b1, 1'b1, RA,     32'h22, 1'b0};
    vt[5] = '{5'd8, 5'd9, 3'b110, {5'd9, 5'd9, 5'd0}, 3'b100, 32'h11,   1'b1, 1'b0, RA,     32'h22, 1'b1};
    vt[6] = '{5'd8, 5'd8, 3'b100, {5'd8, 5'd0, 5'd0}, 3'b000, 32'h11,   1'b1, 1'b0, 32'h33, 32'h33, 1'b0};
    vt[7] = '{5'd3, 5'd9, 3'b000, {5'd3, 5'd9, 5'd3}, 3'b111, 32'h11,   1'b1, 1'b1, RA,     RB,     1'b1};
    vt[8] = '{5'd8, 5'd9, 3'b111, {5'd8, 5'd8, 5'd8}, 3'b011, 32'h11,   1'b1, 1'b1, 32'h11, RB,     1'b1};

    // Reset state
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_allowin", ds_allowin, 1'b1);
    chkb("rst_valid", ds_to_es_valid, 1'b0);
    chk("rst_stall", stall_cnt, 32'd0);
    reset = 1'b0;

    // Table-driven forwarding vectors, held with es_allowin = 0
    for (int k = 0; k < 9; k++) begin
      idle();
      ds_flush = 1'b1;
      @(posedge clk); #1;
      idle();
      load(32'h1000 + 32'(k), mk(vt[k].rs, vt[k].rt));
      @(posedge clk); #1;
      idle();
      es_allowin  = 1'b0;
      dec_rs_used = vt[k].rs_used;
      dec_rt_used = vt[k].rt_used;
      fwd_we      = vt[k].we;
      fwd_waddr   = vt[k].waddr;
      fwd_rdy     = vt[k].rdy;
      fwd_wdata   = {32'h33, 32'h22, vt[k].d0};
      #3;
      chk($sformatf("tbl%0d_rs", k), ds_rs_val, vt[k].exp_rs);
      chk($sformatf("tbl%0d_rt", k), ds_rt_val, vt[k].exp_rt);
      chkb($sformatf("tbl%0d_go", k), ds_to_es_valid, vt[k].exp_go);
      chkb($sformatf("tbl%0d_allowin", k), ds_allowin, 1'b0);
      chk($sformatf("tbl%0d_pc", k), ds_pc, 32'h1000 + 32'(k));
    end

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      es_allowin     = ($urandom_range(0, 3) != 0);
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      fs_to_ds_bus   = {$urandom(), mk(rr(), rr())};
      ds_flush       = ($urandom_range(0, 9) == 0);
      dec_rs_used    = 1'($urandom_range(0, 1));
      dec_rt_used    = 1'($urandom_range(0, 1));
      dec_rf_we      = 1'($urandom_range(0, 1));
      dec_rf_waddr   = rr();
      dec_long_op    = ($urandom_range(0, 2) == 0);
      rs_data        = $urandom();
      rt_data        = $urandom();
      for (int i = 0; i < 3; i++) begin
        fwd_we[i]              = 1'($urandom_range(0, 1));
        fwd_waddr[5*i +: 5]    = rr();
        fwd_wdata[32*i +: 32]  = $urandom();
        fwd_rdy[i]             = ($urandom_range(0, 3) != 0);
      end
      lp_done_valid  = ($urandom_range(0, 2) == 0);
      lp_done_waddr  = rr();
      cycle();
    end

    // Long op to r9, then a reader of r9
    do_reset();
    idle(); load(32'h200, mk(5'd0, 5'd0)); cycle();
    idle(); load(32'h204, mk(5'd9, 5'd0)); long_to(5'd9);
    #3 chkb("lp_issue_a", ds_to_es_valid, 1'b1); cycle();
    idle(); es_allowin = 1'b0; dec_rs_used = 1'b1;
    #3 chkb("lp_stall_bp", ds_to_es_valid, 1'b0); cycle();
    idle(); dec_rs_used = 1'b1; lp_done_valid = 1'b1; lp_done_waddr = 5'd9;
    #3 chkb("lp_stall_done", ds_to_es_valid, 1'b0); cycle();
    idle(); dec_rs_used = 1'b1; fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd9, 5'd0};
    fwd_wdata = {32'h0, 32'h99, 32'h0};
    #3;
    chkb("lp_issue_b", ds_to_es_valid, 1'b1);
    chk("lp_b_val", ds_rs_val, 32'h99);
    chk("lp_stall_cnt", stall_cnt, 32'd1);
    cycle();

    // Scoreboard full with MAX_LONG = 2
    do_reset();
    idle(); load(32'h300, mk(5'd1, 5'd2)); cycle();
    idle(); load(32'h304, mk(5'd1, 5'd2)); long_to(5'd3);
    #3 chkb("full_l1", ds_to_es_valid, 1'b1); cycle();
    idle(); load(32'h308, mk(5'd1, 5'd2)); long_to(5'd4);
    #3 chkb("full_l2", ds_to_es_valid, 1'b1); cycle();
    idle(); long_to(5'd5);
    #3 chkb("full_stall", ds_to_es_valid, 1'b0); cycle();
    idle(); long_to(5'd5); lp_done_valid = 1'b1; lp_done_waddr = 5'd3;
    #3 chkb("full_stall_done", ds_to_es_valid, 1'b0); cycle();
    idle(); long_to(5'd5); load(32'h30C, mk(5'd1, 5'd2));
    #3 chkb("full_release", ds_to_es_valid, 1'b1); cycle();
    idle(); long_to(5'd6);
    #3 chkb("full_again", ds_to_es_valid, 1'b0); cycle();

    // Backpressure and flush
    do_reset();
    idle(); load(32'h400, mk(5'd8, 5'd9)); cycle();
    idle(); es_allowin = 1'b0; load(32'h404, mk(5'd1, 5'd1)); long_to(5'd7);
    #3;
    chkb("bp_valid", ds_to_es_valid, 1'b1);
    chkb("bp_allowin", ds_allowin, 1'b0);
    cycle();
    idle(); es_allowin = 1'b0; long_to(5'd7);
    #3;
    chk("bp_inst_hold", ds_inst, mk(5'd8, 5'd9));
    chk("bp_pc_hold", ds_pc, 32'h400);
    chk("bp_rs_val", ds_rs_val, RA);
    cycle();
    idle(); ds_flush = 1'b1; long_to(5'd7);
    #3 chkb("flush_no_issue", ds_to_es_valid, 1'b0); cycle();
    idle(); load(32'h408, mk(5'd7, 5'd0));
    #3;
    chkb("flush_empty_allowin", ds_allowin, 1'b1);
    chkb("flush_empty_valid", ds_to_es_valid, 1'b0);
    cycle();
    idle(); dec_rs_used = 1'b1;
    #3 chkb("flush_no_set", ds_to_es_valid, 1'b1); cycle();

    // Reset mid-stream with pend[5] set and an instruction held
    do_reset();
    idle(); load(32'h500, mk(5'd0, 5'd0)); cycle();
    idle(); load(32'h504, mk(5'd5, 5'd0)); long_to(5'd5); cycle();
    idle(); dec_rs_used = 1'b1; cycle();
    idle(); dec_rs_used = 1'b1; cycle();
    idle(); dec_rs_used = 1'b1;
    #1 chk("pre_reset_stall", stall_cnt, 32'd2);
    reset = 1'b1;
    #1;
    chkb("mid_rst_valid", ds_to_es_valid, 1'b0);
    chkb("mid_rst_allowin", ds_allowin, 1'b1);
    chk("mid_rst_stall", stall_cnt, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle(); load(32'h508, mk(5'd5, 5'd0)); cycle();
    idle(); dec_rs_used = 1'b1;
    #3 chkb("mid_rst_pend_clear", ds_to_es_valid, 1'b1); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
